// File: rtl/dl_report_pkg.sv
// Shared types and helpers for the deadlock report controller.
package dl_report_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        CLEAR     = 2'd2,
        CONFIRMED = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dl_report_ctrl_if.sv
// Detect-unit <-> report controller bundle; master drives the per-process bits.
interface dl_report_ctrl_if #(
    parameter int PROC_NUM = 4,
    parameter int CNT_W    = 16
);
    localparam int IW = dl_report_pkg::idx_w(PROC_NUM);

    logic [PROC_NUM-1:0] dl_in_vec;
    logic [PROC_NUM-1:0] ap_done_vec;
    logic                all_finish;
    logic                dl_detect_out;
    logic [PROC_NUM-1:0] origin;
    logic                token_clear;
    logic                dl_confirmed;
    logic [IW-1:0]       dl_origin_idx;
    logic [CNT_W-1:0]    dl_abort_cnt;

    modport master (
        output dl_in_vec, ap_done_vec, all_finish,
        input  dl_detect_out, origin, token_clear, dl_confirmed, dl_origin_idx, dl_abort_cnt
    );

    modport slave (
        input  dl_in_vec, ap_done_vec, all_finish,
        output dl_detect_out, origin, token_clear, dl_confirmed, dl_origin_idx, dl_abort_cnt
    );
endinterface

// File: rtl/dl_prio_onehot.sv
// Lowest-index priority select: one-hot, binary index and any-set flag.
// Purely combinational; no backpressure.
module dl_prio_onehot
    import dl_report_pkg::*;
#(
    parameter int PROC_NUM = 4
) (
    input  logic [PROC_NUM-1:0]          vec,
    output logic [PROC_NUM-1:0]          onehot,
    output logic [idx_w(PROC_NUM)-1:0]   idx,
    output logic                         any
);
    localparam int IW = idx_w(PROC_NUM);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = |vec;
        // scan downward so the lowest set bit is the last one written
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IW'(i);
            end
        end
    end
endmodule

// File: rtl/dl_report_ctrl.sv
// Elects a deadlock origin, confirms it after CONFIRM_CYCLES held cycles or aborts with token_clear.
// One edge from sampled input to registered outputs; optional DL_REPORT_FINISH_EN ends the sim on confirm.
module dl_report_ctrl
    import dl_report_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int CONFIRM_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic             dl_clock,
    input  logic             dl_reset,
    dl_report_ctrl_if.slave  bus
);
    localparam int IW = idx_w(PROC_NUM);
    localparam int CW = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CONFIRM_CYCLES - 1);

    state_t              state_q, state_d;
    logic [PROC_NUM-1:0] masked, sel_onehot;
    logic [IW-1:0]       sel_idx;
    logic                sel_any, origin_live;

    logic [PROC_NUM-1:0] origin_q, origin_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                detect_q, detect_d;
    logic                clear_q, clear_d;
    logic                conf_q, conf_d;
    logic [CNT_W-1:0]    abort_q, abort_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    assign masked      = bus.dl_in_vec & ~bus.ap_done_vec & {PROC_NUM{~bus.all_finish}};
    assign origin_live = |(masked & origin_q);

    dl_prio_onehot #(.PROC_NUM(PROC_NUM)) u_prio (
        .vec    (masked),
        .onehot (sel_onehot),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    always_ff @(posedge dl_clock or negedge dl_reset) begin
        if (!dl_reset) begin
            state_q  <= IDLE;
            origin_q <= '0;
            idx_q    <= '0;
            detect_q <= 1'b0;
            clear_q  <= 1'b0;
            conf_q   <= 1'b0;
            abort_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            origin_q <= origin_d;
            idx_q    <= idx_d;
            detect_q <= detect_d;
            clear_q  <= clear_d;
            conf_q   <= conf_d;
            abort_q  <= abort_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (sel_any) state_d = ARM;
            ARM: begin
                // a dropped origin wins over a simultaneous confirm
                if (!origin_live)            state_d = CLEAR;
                else if (cnt_q == CNT_LAST)  state_d = CONFIRMED;
            end
            CLEAR:     state_d = IDLE;
            CONFIRMED: state_d = CONFIRMED;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        origin_d = origin_q;
        idx_d    = idx_q;
        detect_d = detect_q;
        clear_d  = 1'b0;
        conf_d   = conf_q;
        abort_d  = abort_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    origin_d = sel_onehot;
                    idx_d    = sel_idx;
                    detect_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            ARM: begin
                if (!origin_live) begin
                    origin_d = '0;
                    idx_d    = '0;
                    detect_d = 1'b0;
                    clear_d  = 1'b1;
                    if (abort_q != {CNT_W{1'b1}}) abort_d = abort_q + 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    conf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.dl_detect_out = detect_q;
    assign bus.origin        = origin_q;
    assign bus.token_clear   = clear_q;
    assign bus.dl_confirmed  = conf_q;
    assign bus.dl_origin_idx = idx_q;
    assign bus.dl_abort_cnt  = abort_q;

`ifdef DL_REPORT_FINISH_EN
    always @(posedge dl_clock) begin
        if (dl_reset && state_q == ARM && state_d == CONFIRMED)
            $display("dl_report_ctrl: deadlock confirmed, origin %0d at time %0t", idx_q, $time);
        if (dl_reset && state_q == CONFIRMED)
            $finish;
    end
`else
    // simulation keeps running; dl_confirmed is the only report
`endif
endmodule

// File: doc/dl_report_ctrl.md
Name: dl_report_ctrl

Overview:
- Receiving end of the per-process deadlock detect units in the simulation deadlock detector.
- Collects each unit's dl_detect_out bit and elects a single origin process. Broadcasts dl_detect_out and origin back to all units so they stop re-sampling and forward tokens.
- Confirms a deadlock once the origin's detection persists. Otherwise aborts via a token_clear pulse so the ring can retry.

Parameters:
- PROC_NUM, 4, number of monitored processes (>=1).
- CONFIRM_CYCLES, 16, consecutive ARM-state cycles the origin bit must stay high to confirm (>=1).
- CNT_W, 16, width of the abort counter.

Ports:
- dl_clock  input  1  simulation clock, posedge.
- dl_reset  input  1  asynchronous, active-low reset.
- dl_in_vec  input  PROC_NUM  per-process dl_detect_out from the detect units.
- ap_done_vec  input  PROC_NUM  per-process registered done-and-held flag; a set bit excludes that process as an origin candidate.
- all_finish  input  1  design finished; suppresses all detection.
- dl_detect_out  output  1  detection in progress or confirmed; fed back to all units.
- origin  output  PROC_NUM  one-hot elected origin; all zero when not detecting.
- token_clear  output  1  one-cycle pulse that aborts the current attempt.
- dl_confirmed  output  1  sticky deadlock-confirmed flag.
- dl_origin_idx  output  max(1,$clog2(PROC_NUM))  binary index of the origin, valid while dl_detect_out=1.
- dl_abort_cnt  output  CNT_W  count of aborted attempts, saturating.

Behaviour:
- Masking: masked = dl_in_vec & ~ap_done_vec & {PROC_NUM{~all_finish}}.
- Reset: all outputs are registered and reset to 0; the state machine resets to IDLE.
- IDLE:
  - If masked != 0 at a posedge, elect the lowest set index and go to ARM.
  - At that edge: origin <= one-hot(idx), dl_origin_idx <= idx, dl_detect_out <= 1, cnt <= 0.
  - Latency is one edge from sampled input to outputs.
- ARM, at each posedge:
  - If all_finish=1 or masked[idx]=0, go to CLEAR.
  - Else if cnt==CONFIRM_CYCLES-1, go to CONFIRMED and set dl_confirmed <= 1.
  - Else cnt <= cnt+1.
  - Net effect: confirmation occurs at edge E0+CONFIRM_CYCLES, where E0 is the ARM-entry edge.
  - origin stays frozen while in ARM; new bits in other lanes are ignored.
- CLEAR:
  - Held for one cycle with token_clear=1, dl_detect_out=0, origin=0.
  - dl_abort_cnt <= dl_abort_cnt+1, saturating at all-ones.
  - Next state is always IDLE; no re-election is allowed in the CLEAR cycle. Re-election is earliest at the following edge.
- CONFIRMED:
  - Terminal state: dl_detect_out=1, origin and dl_origin_idx held, dl_confirmed=1.
  - All inputs are ignored, including all_finish. Only reset exits.
- Simultaneous events:
  - Several bits set in IDLE: the lowest index wins.
  - Origin bit dropping on the same edge cnt would reach the terminal value: abort takes priority.
- Reset mid-operation: asynchronous return to IDLE; all outputs cleared immediately, including a token_clear pulse in progress.
- token_clear is never asserted outside CLEAR.

Optional Feature:
- Macro: DL_REPORT_FINISH_EN.
- Defined: on the edge entering CONFIRMED, $display reports the origin index and simulation time. The block then calls $finish at the next posedge.
- Undefined: no display and no $finish. Simulation continues, and the bench observes dl_confirmed.

Decomposition:
- Package dl_report_pkg holds:
  - state enum {IDLE, ARM, CLEAR, CONFIRMED}, 2 bits;
  - a localparam function for index width, max(1,$clog2(n)).
- Sub-module dl_prio_onehot: combinational lowest-index priority select that outputs the one-hot vector, the binary index and an any-set flag. Parameterised by PROC_NUM.

Test Plan:
1. PROC_NUM=4, CONFIRM_CYCLES=16; dl_in_vec=4'b0100 held from edge 10 -> after edge 10: origin=4'b0100, dl_origin_idx=2, dl_detect_out=1; after edge 26: dl_confirmed=1; dl_abort_cnt=0.
2. dl_in_vec=4'b0110 at edge 5, bit 1 dropped at edge 9 -> origin=4'b0010 after edge 5; CLEAR after edge 9 with token_clear high one cycle; dl_abort_cnt=1; re-elect origin=4'b0100 after edge 11.
3. ap_done_vec=4'b0001, dl_in_vec=4'b0001 -> stays IDLE; origin=0, dl_detect_out=0 indefinitely.
4. In ARM, all_finish pulsed at edge 8 -> CLEAR and token_clear pulse; all_finish held high -> no re-arm.
5. CONFIRM_CYCLES=1, CNT_W=2, force 5 aborts -> dl_abort_cnt saturates at 3; then a held bit 3 -> dl_confirmed exactly 1 edge after ARM entry.
6. dl_reset low mid-ARM -> all outputs 0 asynchronously; after release with dl_in_vec=0, remains IDLE.
